// File: rtl/cla_pkg.sv
// cla_pkg: shared stage record, group-count helper and configuration check for the pipelined CLA adder
package cla_pkg;
    localparam int CLA_MAX_WIDTH = 64;
    typedef struct packed {
        logic                     valid;
        logic                     carry;
        logic [CLA_MAX_WIDTH-1:0] sum;
        logic [CLA_MAX_WIDTH-1:0] a;
        logic [CLA_MAX_WIDTH-1:0] b;
    } cla_stage_t;
    function automatic int ngrp(input int width, input int group);
        return width / group;
    endfunction
endpackage
`define CLA_CHECK_CFG(W, G) \
    if ((G) < 1 || (W) < (G) || ((W) % (G)) != 0 || (W) > cla_pkg::CLA_MAX_WIDTH) begin : g_bad_cfg \
        $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP within [GROUP, CLA_MAX_WIDTH]"); \
    end

// File: rtl/cla_group.sv
// cla_group: combinational GROUP-bit carry-lookahead block with flat sum-of-products carries
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a_i,
    input  logic [GROUP-1:0] b_i,
    input  logic             cin_i,
    output logic [GROUP-1:0] sum_o,
    output logic             p_o,
    output logic             g_o,
    output logic             cout_o,
    output logic             c_msb_o
);
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;

    function automatic logic prop(input logic [GROUP-1:0] v, input int lo, input int hi);
        prop = 1'b1;
        for (int m = lo; m <= hi; m++) prop = prop & v[m];
    endfunction

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    // every carry is an independent OR of generate/propagate products, never chained through c
    always_comb begin
        c = '0;
        c[0] = cin_i;
        g_o = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            c[i+1] = cin_i & prop(p, 0, i);
            for (int j = 0; j <= i; j++) c[i+1] = c[i+1] | (g[j] & prop(p, j + 1, i));
        end
        for (int j = 0; j < GROUP; j++) g_o = g_o | (g[j] & prop(p, j + 1, GROUP - 1));
    end

    assign p_o     = &p;
    assign sum_o   = p ^ c[GROUP-1:0];
    assign cout_o  = c[GROUP];
    assign c_msb_o = c[GROUP-1];
endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: WIDTH-bit adder resolving one GROUP-bit lookahead group per stage with valid/ready flow control; CLA_OVF_EN adds the ovf port
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef CLA_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);
    localparam int NGRP = ngrp(WIDTH, GROUP);
    `CLA_CHECK_CFG(WIDTH, GROUP)

    logic             adv;
    cla_stage_t       st_q     [NGRP];
    cla_stage_t       st_in    [NGRP];
    cla_stage_t       st_d     [NGRP];
    logic [GROUP-1:0] grp_sum  [NGRP];
    logic [NGRP-1:0]  grp_p;
    logic [NGRP-1:0]  grp_g;
    logic [NGRP-1:0]  grp_cout;
    logic [NGRP-1:0]  grp_cmsb;
    logic             unused_grp;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // stage 0 works on the ports, every later stage on the record held by its predecessor
    always_comb begin
        st_in[0] = '{valid: in_valid, carry: cin, sum: '0, a: CLA_MAX_WIDTH'(a), b: CLA_MAX_WIDTH'(b)};
        for (int k = 1; k < NGRP; k++) st_in[k] = st_q[k-1];
    end

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        cla_group #(.GROUP(GROUP)) u_grp (
            .a_i    (st_in[k].a[k*GROUP +: GROUP]),
            .b_i    (st_in[k].b[k*GROUP +: GROUP]),
            .cin_i  (st_in[k].carry),
            .sum_o  (grp_sum[k]),
            .p_o    (grp_p[k]),
            .g_o    (grp_g[k]),
            .cout_o (grp_cout[k]),
            .c_msb_o(grp_cmsb[k])
        );
    end

    // drop each group's sum slice into the travelling record and replace the carry with its group carry
    always_comb begin
        for (int k = 0; k < NGRP; k++) begin
            st_d[k] = st_in[k];
            st_d[k].sum[k*GROUP +: GROUP] = grp_sum[k];
            st_d[k].carry = grp_cout[k];
        end
    end

    // all stages move together on advance and freeze together on a stall; reset discards everything in flight
    always_ff @(posedge clk) begin
        if (rst) st_q <= '{default: '0};
        else if (adv) st_q <= st_d;
    end

    assign out_valid  = st_q[NGRP-1].valid;
    assign sum        = st_q[NGRP-1].sum[WIDTH-1:0];
    assign cout       = st_q[NGRP-1].carry;
    assign unused_grp = ^{grp_p, grp_g, grp_cmsb};

`ifdef CLA_OVF_EN
    logic ovf_d;
    logic ovf_q;

    assign ovf_d = grp_cmsb[NGRP-1] ^ grp_cout[NGRP-1];

    // overflow is captured in lockstep with the final stage so it stays aligned with sum
    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else if (adv) ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: directed vector table plus stall and mid-flight reset sequences
module tb_pipelined_cla_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
`ifdef CLA_OVF_EN
    logic        ovf;
`endif
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
`ifdef CLA_OVF_EN
        .ovf      (ovf),
`endif
        .cout     (cout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
    endtask

    task automatic single_op(input string tag, input logic [15:0] av, input logic [15:0] bv, input logic cv,
                             input logic [15:0] es, input logic ec);
        in_valid = 1'b1;
        a = av;
        b = bv;
        cin = cv;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 1) idle_inputs();
            chk({tag, "_lat_valid"}, 32'(out_valid), 32'(c == 4));
        end
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        step();
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] bp_a [8];
        logic [15:0] bp_b [8];
        logic        bp_c [8];
        logic [16:0] bp_exp [8];
        int          issue;
        int          ridx;
        logic        exp_rdy;

        vecs[0]  = '{16'h0004, 16'h0002, 1'b0, 16'h0006, 1'b0, 1'b0};
        vecs[1]  = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[2]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4]  = '{16'h000A, 16'h0005, 1'b1, 16'h0010, 1'b0, 1'b0};
        vecs[5]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[8]  = '{16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[9]  = '{16'hF000, 16'h1000, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[10] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0};
        vecs[11] = '{16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[12] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};

        rst = 1'b1;
        out_ready = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef CLA_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif

        single_op("single", 16'h0004, 16'h0002, 1'b0, 16'h0006, 1'b0);

        issue = 0;
        ridx = 0;
        for (int c = 0; c < 40 && ridx < NV; c++) begin
            if (issue < NV) begin
                in_valid = 1'b1;
                a = vecs[issue].a;
                b = vecs[issue].b;
                cin = vecs[issue].cin;
            end else idle_inputs();
            #1;
            chk("tbl_in_ready", 32'(in_ready), 32'd1);
            if (out_valid) begin
                chk($sformatf("tbl%0d_sum", ridx), 32'(sum), 32'(vecs[ridx].sum));
                chk($sformatf("tbl%0d_cout", ridx), 32'(cout), 32'(vecs[ridx].cout));
`ifdef CLA_OVF_EN
                chk($sformatf("tbl%0d_ovf", ridx), 32'(ovf), 32'(vecs[ridx].ovf));
`endif
                ridx++;
            end
            if (in_valid && in_ready) issue++;
            step();
        end
        chk("tbl_count", 32'(ridx), 32'(NV));
        idle_inputs();
        step();

        for (int i = 0; i < 8; i++) begin
            bp_a[i] = 16'(16'h2000 * i + 16'h0123 * i);
            bp_b[i] = 16'hF00F;
            bp_c[i] = 1'(i % 2);
            bp_exp[i] = {1'b0, bp_a[i]} + {1'b0, bp_b[i]} + {16'b0, bp_c[i]};
        end
        issue = 0;
        ridx = 0;
        for (int c = 0; c < 40 && ridx < 8; c++) begin
            if (issue < 8) begin
                in_valid = 1'b1;
                a = bp_a[issue];
                b = bp_b[issue];
                cin = bp_c[issue];
            end else idle_inputs();
            exp_rdy = !(c >= 5 && c <= 7);
            out_ready = exp_rdy;
            #1;
            chk($sformatf("bp_in_ready_c%0d", c), 32'(in_ready), 32'(exp_rdy));
            if (out_valid) begin
                chk($sformatf("bp%0d_sum", ridx), 32'(sum), 32'(bp_exp[ridx][15:0]));
                chk($sformatf("bp%0d_cout", ridx), 32'(cout), 32'(bp_exp[ridx][16]));
                if (out_ready) ridx++;
            end
            if (in_valid && in_ready) issue++;
            step();
        end
        chk("bp_count", 32'(ridx), 32'd8);
        chk("bp_issued", 32'(issue), 32'd8);
        out_ready = 1'b1;
        idle_inputs();
        step();
        chk("bp_drained", 32'(out_valid), 32'd0);

        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 16'h0101 * 16'(i + 1);
            b = 16'h0010;
            cin = 1'b0;
            step();
        end
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_cout", 32'(cout), 32'd0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("mid_rst_quiet%0d", c), 32'(out_valid), 32'd0);
        end
        single_op("after_rst", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
